// File: rtl/axi_lite_rr_arbiter.sv
// AXI-Lite round-robin arbiter: several AXI-Lite requesters share one
// AXI-Lite master port. Reads and writes are arbitrated independently, each
// with its own round-robin pointer and one outstanding transaction. The
// granted requester's request channels are mirrored to the master port and
// the master responses are routed back to that requester only.
module axi_lite_rr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    // requester side (requester i occupies slice i)
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   slv_aw_awaddr,
    input  logic [NUM_REQ*3-1:0]                slv_aw_awprot,
    input  logic [NUM_REQ-1:0]                  slv_aw_awvalid,
    output logic [NUM_REQ-1:0]                  slv_aw_awready,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   slv_w_wdata,
    input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0] slv_w_wstrb,
    input  logic [NUM_REQ-1:0]                  slv_w_wvalid,
    output logic [NUM_REQ-1:0]                  slv_w_wready,
    output logic [NUM_REQ*2-1:0]                slv_b_bresp,
    output logic [NUM_REQ-1:0]                  slv_b_bvalid,
    input  logic [NUM_REQ-1:0]                  slv_b_bready,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   slv_ar_araddr,
    input  logic [NUM_REQ*3-1:0]                slv_ar_arprot,
    input  logic [NUM_REQ-1:0]                  slv_ar_arvalid,
    output logic [NUM_REQ-1:0]                  slv_ar_arready,
    output logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   slv_r_rdata,
    output logic [NUM_REQ*2-1:0]                slv_r_rresp,
    output logic [NUM_REQ-1:0]                  slv_r_rvalid,
    input  logic [NUM_REQ-1:0]                  slv_r_rready,
    // master side
    output logic [AXI_ADDR_WIDTH-1:0]           mst_aw_awaddr,
    output logic [2:0]                          mst_aw_awprot,
    output logic                                mst_aw_awvalid,
    input  logic                                mst_aw_awready,
    output logic [AXI_DATA_WIDTH-1:0]           mst_w_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]         mst_w_wstrb,
    output logic                                mst_w_wvalid,
    input  logic                                mst_w_wready,
    input  logic [1:0]                          mst_b_bresp,
    input  logic                                mst_b_bvalid,
    output logic                                mst_b_bready,
    output logic [AXI_ADDR_WIDTH-1:0]           mst_ar_araddr,
    output logic [2:0]                          mst_ar_arprot,
    output logic                                mst_ar_arvalid,
    input  logic                                mst_ar_arready,
    input  logic [AXI_DATA_WIDTH-1:0]           mst_r_rdata,
    input  logic [1:0]                          mst_r_rresp,
    input  logic                                mst_r_rvalid,
    output logic                                mst_r_rready
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_e;

    wr_state_e         wr_state_q, wr_state_d;
    logic [IDX_W-1:0]  wr_gnt_q, wr_gnt_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    rd_state_e         rd_state_q, rd_state_d;
    logic [IDX_W-1:0]  rd_gnt_q, rd_gnt_d;
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;

    // First requesting index at or after ptr, wrapping around. Scanning from
    // the farthest offset down lets the nearest candidate win.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] win;
        int               idx;
        win = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) win = IDX_W'(idx);
        end
        return win;
    endfunction

    // Pointer moves to the requester just after the one that was served.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] gnt);
        return (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
    endfunction

    // Write arbitration state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_q <= W_IDLE;
            wr_gnt_q   <= '0;
            wr_ptr_q   <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_gnt_q   <= wr_gnt_d;
            wr_ptr_q   <= wr_ptr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Write FSM: grant, forward AW/W of the granted requester, route B back.
    always_comb begin
        wr_state_d     = wr_state_q;
        wr_gnt_d       = wr_gnt_q;
        wr_ptr_d       = wr_ptr_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        mst_aw_awaddr  = '0;
        mst_aw_awprot  = '0;
        mst_aw_awvalid = 1'b0;
        mst_w_wdata    = '0;
        mst_w_wstrb    = '0;
        mst_w_wvalid   = 1'b0;
        mst_b_bready   = 1'b0;
        slv_aw_awready = '0;
        slv_w_wready   = '0;
        slv_b_bvalid   = '0;
        slv_b_bresp    = '0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (|slv_aw_awvalid) begin
                    wr_gnt_d   = rr_pick(slv_aw_awvalid, wr_ptr_q);
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                mst_aw_awaddr  = slv_aw_awaddr[int'(wr_gnt_q)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                mst_aw_awprot  = slv_aw_awprot[int'(wr_gnt_q)*3 +: 3];
                mst_aw_awvalid = !aw_done_q;
                mst_w_wdata    = slv_w_wdata[int'(wr_gnt_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                mst_w_wstrb    = slv_w_wstrb[int'(wr_gnt_q)*STRB_WIDTH +: STRB_WIDTH];
                mst_w_wvalid   = slv_w_wvalid[wr_gnt_q] & !w_done_q;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == int'(wr_gnt_q)) begin
                        slv_aw_awready[i] = mst_aw_awready & !aw_done_q;
                        slv_w_wready[i]   = mst_w_wready & !w_done_q;
                    end
                end
                if (!aw_done_q && mst_aw_awready) aw_done_d = 1'b1;
                if (slv_w_wvalid[wr_gnt_q] && !w_done_q && mst_w_wready) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) wr_state_d = W_RESP;
            end
            W_RESP: begin
                mst_b_bready = slv_b_bready[wr_gnt_q];
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == int'(wr_gnt_q)) begin
                        slv_b_bvalid[i]      = mst_b_bvalid;
                        slv_b_bresp[i*2 +: 2] = mst_b_bresp;
                    end
                end
                if (mst_b_bvalid && slv_b_bready[wr_gnt_q]) begin
                    wr_ptr_d   = rr_next(wr_gnt_q);
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read arbitration state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_q <= R_IDLE;
            rd_gnt_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Read FSM: grant, forward AR of the granted requester, route R back.
    always_comb begin
        rd_state_d     = rd_state_q;
        rd_gnt_d       = rd_gnt_q;
        rd_ptr_d       = rd_ptr_q;
        mst_ar_araddr  = '0;
        mst_ar_arprot  = '0;
        mst_ar_arvalid = 1'b0;
        mst_r_rready   = 1'b0;
        slv_ar_arready = '0;
        slv_r_rvalid   = '0;
        slv_r_rdata    = '0;
        slv_r_rresp    = '0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (|slv_ar_arvalid) begin
                    rd_gnt_d   = rr_pick(slv_ar_arvalid, rd_ptr_q);
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                mst_ar_araddr  = slv_ar_araddr[int'(rd_gnt_q)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                mst_ar_arprot  = slv_ar_arprot[int'(rd_gnt_q)*3 +: 3];
                mst_ar_arvalid = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == int'(rd_gnt_q)) slv_ar_arready[i] = mst_ar_arready;
                end
                if (mst_ar_arready) rd_state_d = R_RESP;
            end
            R_RESP: begin
                mst_r_rready = slv_r_rready[rd_gnt_q];
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == int'(rd_gnt_q)) begin
                        slv_r_rvalid[i]                               = mst_r_rvalid;
                        slv_r_rdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = mst_r_rdata;
                        slv_r_rresp[i*2 +: 2]                          = mst_r_rresp;
                    end
                end
                if (mst_r_rvalid && slv_r_rready[rd_gnt_q]) begin
                    rd_ptr_d   = rr_next(rd_gnt_q);
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Testbench for axi_lite_rr_arbiter: requester driver tasks, a simple
// always-ready slave model on the master port, and a scoreboard whose
// expectations (master-side order and requester-side routing) are queued
// by the test sequence and consumed by a monitor.
module tb_axi_lite_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic clk_i = 1'b0;
    logic rst_ni;

    logic [N*AW-1:0] slv_aw_awaddr;
    logic [N*3-1:0]  slv_aw_awprot;
    logic [N-1:0]    slv_aw_awvalid, slv_aw_awready;
    logic [N*DW-1:0] slv_w_wdata;
    logic [N*SW-1:0] slv_w_wstrb;
    logic [N-1:0]    slv_w_wvalid, slv_w_wready;
    logic [N*2-1:0]  slv_b_bresp;
    logic [N-1:0]    slv_b_bvalid, slv_b_bready;
    logic [N*AW-1:0] slv_ar_araddr;
    logic [N*3-1:0]  slv_ar_arprot;
    logic [N-1:0]    slv_ar_arvalid, slv_ar_arready;
    logic [N*DW-1:0] slv_r_rdata;
    logic [N*2-1:0]  slv_r_rresp;
    logic [N-1:0]    slv_r_rvalid, slv_r_rready;

    logic [AW-1:0] mst_aw_awaddr;
    logic [2:0]    mst_aw_awprot;
    logic          mst_aw_awvalid, mst_aw_awready;
    logic [DW-1:0] mst_w_wdata;
    logic [SW-1:0] mst_w_wstrb;
    logic          mst_w_wvalid, mst_w_wready;
    logic [1:0]    mst_b_bresp;
    logic          mst_b_bvalid, mst_b_bready;
    logic [AW-1:0] mst_ar_araddr;
    logic [2:0]    mst_ar_arprot;
    logic          mst_ar_arvalid, mst_ar_arready;
    logic [DW-1:0] mst_r_rdata;
    logic [1:0]    mst_r_rresp;
    logic          mst_r_rvalid, mst_r_rready;

    int checks   = 0;
    int failures = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    logic overlap_seen = 1'b0;
    logic [1:0] bresp_cfg = 2'b00;

    logic [127:0] exp_aw_q[$];
    logic [127:0] exp_w_q[$];
    logic [127:0] exp_ar_q[$];
    rsp_t         exp_b_q[$];
    rsp_t         exp_r_q[$];

    axi_lite_rr_arbiter #(
        .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .slv_aw_awaddr(slv_aw_awaddr), .slv_aw_awprot(slv_aw_awprot),
        .slv_aw_awvalid(slv_aw_awvalid), .slv_aw_awready(slv_aw_awready),
        .slv_w_wdata(slv_w_wdata), .slv_w_wstrb(slv_w_wstrb),
        .slv_w_wvalid(slv_w_wvalid), .slv_w_wready(slv_w_wready),
        .slv_b_bresp(slv_b_bresp), .slv_b_bvalid(slv_b_bvalid), .slv_b_bready(slv_b_bready),
        .slv_ar_araddr(slv_ar_araddr), .slv_ar_arprot(slv_ar_arprot),
        .slv_ar_arvalid(slv_ar_arvalid), .slv_ar_arready(slv_ar_arready),
        .slv_r_rdata(slv_r_rdata), .slv_r_rresp(slv_r_rresp),
        .slv_r_rvalid(slv_r_rvalid), .slv_r_rready(slv_r_rready),
        .mst_aw_awaddr(mst_aw_awaddr), .mst_aw_awprot(mst_aw_awprot),
        .mst_aw_awvalid(mst_aw_awvalid), .mst_aw_awready(mst_aw_awready),
        .mst_w_wdata(mst_w_wdata), .mst_w_wstrb(mst_w_wstrb),
        .mst_w_wvalid(mst_w_wvalid), .mst_w_wready(mst_w_wready),
        .mst_b_bresp(mst_b_bresp), .mst_b_bvalid(mst_b_bvalid), .mst_b_bready(mst_b_bready),
        .mst_ar_araddr(mst_ar_araddr), .mst_ar_arprot(mst_ar_arprot),
        .mst_ar_arvalid(mst_ar_arvalid), .mst_ar_arready(mst_ar_arready),
        .mst_r_rdata(mst_r_rdata), .mst_r_rresp(mst_r_rresp),
        .mst_r_rvalid(mst_r_rvalid), .mst_r_rready(mst_r_rready)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Queue expectations for one write from requester id.
    task automatic push_wr(input int id, input logic [63:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
        rsp_t e;
        exp_aw_q.push_back({61'd0, 3'(id + 1), addr});
        exp_w_q.push_back({92'd0, strb, data});
        e.id = id; e.data = '0; e.resp = resp;
        exp_b_q.push_back(e);
    endtask

    task automatic push_rd(input int id, input logic [63:0] addr, input logic [31:0] data);
        rsp_t e;
        exp_ar_q.push_back({61'd0, 3'(id + 4), addr});
        e.id = id; e.data = data; e.resp = 2'b00;
        exp_r_q.push_back(e);
    endtask

    // Requester write: optional early W, AW/W handshakes, then B (or just
    // wait for B to be offered when hold_b is set).
    task automatic wr_req(input int id, input logic [63:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, input bit chk_lat,
                          input bit hold_b);
        bit aw_ok, w_ok, b_ok;
        int n, aw_at;
        slv_w_wdata[id*DW +: DW] = data;
        slv_w_wstrb[id*SW +: SW] = strb;
        if (w_lead > 0) begin
            slv_w_wvalid[id] = 1'b1;
            repeat (w_lead) begin
                @(negedge clk_i);
                chk("w_held_before_grant", 128'(slv_w_wready[id]), 128'(0));
                @(posedge clk_i); #1;
            end
        end
        slv_aw_awaddr[id*AW +: AW] = addr;
        slv_aw_awprot[id*3 +: 3]   = 3'(id + 1);
        slv_aw_awvalid[id] = 1'b1;
        slv_w_wvalid[id]   = 1'b1;
        aw_ok = 0; w_ok = 0; n = 0; aw_at = -1;
        while (!(aw_ok && w_ok) && n < 40) begin
            @(negedge clk_i);
            if (chk_lat && n == 0) chk("aw_valid_in_grant_cycle", 128'(mst_aw_awvalid), 128'(0));
            if (!aw_ok && slv_aw_awvalid[id] && slv_aw_awready[id]) begin aw_ok = 1; aw_at = n; end
            if (!w_ok && slv_w_wvalid[id] && slv_w_wready[id]) w_ok = 1;
            @(posedge clk_i); #1;
            if (aw_ok) slv_aw_awvalid[id] = 1'b0;
            if (w_ok)  slv_w_wvalid[id]   = 1'b0;
            n++;
        end
        chk("wr_addr_phase_done", 128'({aw_ok, w_ok}), 128'(2'b11));
        if (chk_lat) chk("aw_handshake_latency", 128'(aw_at), 128'(1));
        slv_b_bready[id] = !hold_b;
        b_ok = 0; n = 0;
        while (!b_ok && n < 40) begin
            @(negedge clk_i);
            if (slv_b_bvalid[id]) b_ok = 1;
            @(posedge clk_i); #1;
            n++;
        end
        slv_b_bready[id] = 1'b0;
        chk("b_received", 128'(b_ok), 128'(1));
        $display("[%0t] write id=%0d addr=0x%0h data=0x%0h done", $time, id, addr, data);
    endtask

    task automatic rd_req(input int id, input logic [63:0] addr);
        bit ar_ok, r_ok;
        int n;
        slv_ar_araddr[id*AW +: AW] = addr;
        slv_ar_arprot[id*3 +: 3]   = 3'(id + 4);
        slv_ar_arvalid[id] = 1'b1;
        ar_ok = 0; n = 0;
        while (!ar_ok && n < 40) begin
            @(negedge clk_i);
            if (slv_ar_arready[id]) ar_ok = 1;
            @(posedge clk_i); #1;
            n++;
        end
        slv_ar_arvalid[id] = 1'b0;
        chk("ar_accepted", 128'(ar_ok), 128'(1));
        slv_r_rready[id] = 1'b1;
        r_ok = 0; n = 0;
        while (!r_ok && n < 40) begin
            @(negedge clk_i);
            if (slv_r_rvalid[id]) r_ok = 1;
            @(posedge clk_i); #1;
            n++;
        end
        slv_r_rready[id] = 1'b0;
        chk("r_received", 128'(r_ok), 128'(1));
        $display("[%0t] read  id=%0d addr=0x%0h done", $time, id, addr);
    endtask

    // Slave model on the master port: always ready, B one cycle after both
    // AW and W, R one cycle after AR with data derived from the address.
    initial begin : slave_model
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w;
        logic [AW-1:0] ar_cap;
        mst_aw_awready = 0; mst_w_wready = 0; mst_ar_arready = 0;
        mst_b_bvalid = 0; mst_b_bresp = '0;
        mst_r_rvalid = 0; mst_r_rdata = '0; mst_r_rresp = '0;
        got_aw = 0; got_w = 0; ar_cap = '0;
        forever begin
            @(negedge clk_i);
            aw_hs = mst_aw_awvalid & mst_aw_awready;
            w_hs  = mst_w_wvalid & mst_w_wready;
            b_hs  = mst_b_bvalid & mst_b_bready;
            ar_hs = mst_ar_arvalid & mst_ar_arready;
            r_hs  = mst_r_rvalid & mst_r_rready;
            if (ar_hs) ar_cap = mst_ar_araddr;
            @(posedge clk_i); #1;
            if (!rst_ni) begin
                mst_aw_awready = 0; mst_w_wready = 0; mst_ar_arready = 0;
                mst_b_bvalid = 0; mst_b_bresp = '0;
                mst_r_rvalid = 0; mst_r_rdata = '0; mst_r_rresp = '0;
                got_aw = 0; got_w = 0;
            end else begin
                mst_aw_awready = 1; mst_w_wready = 1; mst_ar_arready = 1;
                if (aw_hs) got_aw = 1;
                if (w_hs)  got_w = 1;
                if (b_hs) begin mst_b_bvalid = 0; mst_b_bresp = '0; end
                if (got_aw && got_w && !mst_b_bvalid) begin
                    mst_b_bvalid = 1; mst_b_bresp = bresp_cfg; got_aw = 0; got_w = 0;
                end
                if (r_hs) begin mst_r_rvalid = 0; mst_r_rdata = '0; end
                if (ar_hs) begin
                    mst_r_rvalid = 1;
                    mst_r_rdata  = ar_cap[31:0] | (ar_cap[31:0] >> 4);
                end
            end
        end
    end

    // Scoreboard monitor: master-side order and requester-side routing.
    initial begin : monitor
        logic [127:0] e;
        rsp_t         er;
        logic [N-1:0]    ev_v;
        logic [N*DW-1:0] ev_d;
        logic [N*2-1:0]  ev_r;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (mst_aw_awvalid && mst_ar_arvalid) overlap_seen = 1'b1;
                if (mst_aw_awvalid && mst_aw_awready) begin
                    aw_cnt++;
                    chk("aw_expected", 128'(exp_aw_q.size() > 0), 128'(1));
                    if (exp_aw_q.size() > 0) begin
                        e = exp_aw_q.pop_front();
                        chk("mst_aw_prot_addr", {61'd0, mst_aw_awprot, mst_aw_awaddr}, e);
                    end
                end
                if (mst_w_wvalid && mst_w_wready) begin
                    w_cnt++;
                    chk("w_expected", 128'(exp_w_q.size() > 0), 128'(1));
                    if (exp_w_q.size() > 0) begin
                        e = exp_w_q.pop_front();
                        chk("mst_w_strb_data", {92'd0, mst_w_wstrb, mst_w_wdata}, e);
                    end
                end
                if (mst_ar_arvalid && mst_ar_arready) begin
                    chk("ar_expected", 128'(exp_ar_q.size() > 0), 128'(1));
                    if (exp_ar_q.size() > 0) begin
                        e = exp_ar_q.pop_front();
                        chk("mst_ar_prot_addr", {61'd0, mst_ar_arprot, mst_ar_araddr}, e);
                    end
                end
                if (slv_b_bvalid != '0) begin
                    chk("b_expected", 128'(exp_b_q.size() > 0), 128'(1));
                    if (exp_b_q.size() > 0) begin
                        er = exp_b_q[0];
                        ev_v = '0; ev_v[er.id] = 1'b1;
                        ev_r = '0; ev_r[er.id*2 +: 2] = er.resp;
                        chk("slv_b_bvalid_vec", 128'(slv_b_bvalid), 128'(ev_v));
                        chk("slv_b_bresp_vec", 128'(slv_b_bresp), 128'(ev_r));
                        if ((slv_b_bvalid & slv_b_bready) != '0) void'(exp_b_q.pop_front());
                    end
                end
                if (slv_r_rvalid != '0) begin
                    chk("r_expected", 128'(exp_r_q.size() > 0), 128'(1));
                    if (exp_r_q.size() > 0) begin
                        er = exp_r_q[0];
                        ev_v = '0; ev_v[er.id] = 1'b1;
                        ev_d = '0; ev_d[er.id*DW +: DW] = er.data;
                        ev_r = '0; ev_r[er.id*2 +: 2] = er.resp;
                        chk("slv_r_rvalid_vec", 128'(slv_r_rvalid), 128'(ev_v));
                        chk("slv_r_rdata_vec", 128'(slv_r_rdata), 128'(ev_d));
                        chk("slv_r_rresp_vec", 128'(slv_r_rresp), 128'(ev_r));
                        if ((slv_r_rvalid & slv_r_rready) != '0) void'(exp_r_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] handshake_outs();
        return 128'({slv_aw_awready, slv_w_wready, slv_b_bvalid, slv_ar_arready, slv_r_rvalid,
                     mst_aw_awvalid, mst_w_wvalid, mst_b_bready, mst_ar_arvalid, mst_r_rready});
    endfunction

    function automatic logic data_outs_nonzero();
        return |{slv_b_bresp, slv_r_rdata, slv_r_rresp, mst_aw_awaddr, mst_aw_awprot,
                 mst_w_wdata, mst_w_wstrb, mst_ar_araddr, mst_ar_arprot};
    endfunction

    initial begin : sequence_main
        int aw0, w0;
        rst_ni = 1'b0;
        slv_aw_awaddr = '0; slv_aw_awprot = '0; slv_aw_awvalid = '0;
        slv_w_wdata = '0; slv_w_wstrb = '0; slv_w_wvalid = '0; slv_b_bready = '0;
        slv_ar_araddr = '0; slv_ar_arprot = '0; slv_ar_arvalid = '0; slv_r_rready = '0;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("reset_handshake_outs", handshake_outs(), 128'(0));
        chk("reset_data_outs", 128'(data_outs_nonzero()), 128'(0));
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle_handshake_outs", handshake_outs(), 128'(0));
        @(posedge clk_i); #1;

        // Single write from requester 1
        push_wr(1, 64'h40, 32'hDEADBEEF, 4'hF, 2'b00);
        wr_req(1, 64'h40, 32'hDEADBEEF, 4'hF, 0, 1'b1, 1'b0);

        // wr_ptr back at 0: requester 0 wins a tie
        push_wr(0, 64'h100, 32'hA0A0A0A0, 4'hF, 2'b00);
        push_wr(1, 64'h104, 32'hB1B1B1B1, 4'hC, 2'b00);
        fork
            wr_req(0, 64'h100, 32'hA0A0A0A0, 4'hF, 0, 1'b0, 1'b0);
            wr_req(1, 64'h104, 32'hB1B1B1B1, 4'hC, 0, 1'b0, 1'b0);
        join

        // Simultaneous reads: requester 0 first, then 1
        push_rd(0, 64'h10, 32'h11);
        push_rd(1, 64'h20, 32'h22);
        fork
            rd_req(0, 64'h10);
            rd_req(1, 64'h20);
        join

        // W arrives 3 cycles before AW (requester 0)
        aw0 = aw_cnt; w0 = w_cnt;
        push_wr(0, 64'h80, 32'h0BADF00D, 4'h5, 2'b00);
        wr_req(0, 64'h80, 32'h0BADF00D, 4'h5, 3, 1'b1, 1'b0);
        chk("early_w_aw_hs_count", 128'(aw_cnt - aw0), 128'(1));
        chk("early_w_w_hs_count", 128'(w_cnt - w0), 128'(1));

        // wr_ptr now 1: requester 1 wins a tie
        push_wr(1, 64'h204, 32'h22220001, 4'hF, 2'b00);
        push_wr(0, 64'h200, 32'h11110000, 4'hF, 2'b00);
        fork
            wr_req(0, 64'h200, 32'h11110000, 4'hF, 0, 1'b0, 1'b0);
            wr_req(1, 64'h204, 32'h22220001, 4'hF, 0, 1'b0, 1'b0);
        join

        // Concurrent write (requester 0) and read (requester 1)
        overlap_seen = 1'b0;
        push_wr(0, 64'h400, 32'h12345678, 4'h3, 2'b00);
        push_rd(1, 64'h30, 32'h33);
        fork
            wr_req(0, 64'h400, 32'h12345678, 4'h3, 0, 1'b0, 1'b0);
            rd_req(1, 64'h30);
        join
        chk("wr_rd_overlap", 128'(overlap_seen), 128'(1));

        // Error response routed to requester 1 only
        bresp_cfg = 2'b10;
        push_wr(1, 64'h500, 32'hCAFE0001, 4'hF, 2'b10);
        wr_req(1, 64'h500, 32'hCAFE0001, 4'hF, 0, 1'b0, 1'b0);
        bresp_cfg = 2'b00;

        // Reset while waiting in W_RESP
        push_wr(1, 64'h600, 32'h55AA55AA, 4'hF, 2'b00);
        wr_req(1, 64'h600, 32'h55AA55AA, 4'hF, 0, 1'b0, 1'b1);
        @(negedge clk_i); #2;
        chk("pre_reset_bvalid1", 128'(slv_b_bvalid[1]), 128'(1));
        rst_ni = 1'b0;
        #1;
        chk("async_reset_handshake_outs", handshake_outs(), 128'(0));
        chk("async_reset_data_outs", 128'(data_outs_nonzero()), 128'(0));
        exp_b_q.delete();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        push_wr(1, 64'h700, 32'h0F0F0F0F, 4'hF, 2'b00);
        wr_req(1, 64'h700, 32'h0F0F0F0F, 4'hF, 0, 1'b1, 1'b0);

        repeat (3) @(negedge clk_i);
        chk("scoreboard_empty",
            128'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_b_q.size() + exp_r_q.size()),
            128'(0));
        chk("final_idle_handshake_outs", handshake_outs(), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
